// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter with prefix claims and redirect squash
package wb_arbiter_pkg;
  typedef struct packed {
    logic [15:0] opid;
    logic [31:0] data;
  } exe_bundle_t;
  typedef struct packed {
    logic [15:0] opid;
    logic [15:0] topid;
  } red_bundle_t;
endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int nfu  = 4,
  parameter int ewd  = 4,
  parameter int wbw  = 2,
  parameter int opsz = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  red_bundle_t                 redir,
  input  exe_bundle_t [nfu-1:0][ewd-1:0] resp,
  output logic        [nfu-1:0][ewd-1:0] claim,
  output exe_bundle_t [wbw-1:0]       wb
);
  localparam int pw = nfu > 1 ? $clog2(nfu) : 1;
  localparam int ow = $clog2(opsz);
  logic [pw-1:0] rr_ptr, rr_next, last;
  logic [nfu-1:0][ewd-1:0] claim_c;
  exe_bundle_t [wbw-1:0] wb_d;
  logic any, open;
  int cnt;
  function automatic logic young(input logic [15:0] x, input red_bundle_t r);
    logic [ow-1:0] dx, dr;
    dx = x[ow-1:0] - r.topid[ow-1:0];
    dr = r.opid[ow-1:0] - r.topid[ow-1:0];
    return r.opid[15] && x[15] && ({1'b0, dx} >= {1'b0, dr} + (ow+1)'(1));
  endfunction
  // scan FUs from rr_ptr, granting each FU's valid prefix until wbw ports are used
  always_comb begin
    claim_c = '0;
    wb_d = '0;
    cnt = 0;
    last = rr_ptr;
    any = 1'b0;
    open = 1'b0;
    for (int k = 0; k < nfu; k++)
      for (int u = 0; u < nfu; u++)
        if ((int'(rr_ptr) + k) % nfu == u) begin
          open = 1'b1;
          for (int s = 0; s < ewd; s++) begin
            open = open && resp[u][s].opid[15] && cnt < wbw;
            if (open) begin
              claim_c[u][s] = 1'b1;
              for (int p = 0; p < wbw; p++)
                if (cnt == p) wb_d[p] = young(resp[u][s].opid, redir) ? '0 : resp[u][s];
              cnt = cnt + 1;
              last = pw'(u);
              any = 1'b1;
            end
          end
        end
  end
  // next round-robin start: one past the last FU granted, held when idle
  always_comb rr_next = any ? (last == pw'(nfu-1) ? '0 : last + pw'(1)) : rr_ptr;
  assign claim = rst ? '0 : claim_c;
  // register writeback ports and round-robin pointer
  always_ff @(posedge clk) begin
    rr_ptr <= rst ? '0 : rr_next;
    wb <= rst ? '0 : wb_d;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table-driven directed check of claims and writeback ports
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int nfu = 4, ewd = 4, wbw = 2;
  typedef struct {
    logic rst;
    red_bundle_t redir;
    exe_bundle_t [nfu-1:0][ewd-1:0] resp;
    logic [nfu-1:0][ewd-1:0] claim;
    exe_bundle_t [wbw-1:0] wb;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  red_bundle_t redir;
  exe_bundle_t [nfu-1:0][ewd-1:0] resp;
  logic [nfu-1:0][ewd-1:0] claim;
  exe_bundle_t [wbw-1:0] wb;
  vec_t tv[$];
  vec_t cur;
  int checks = 0;
  int failures = 0;
  wb_arbiter #(.nfu(nfu), .ewd(ewd), .wbw(wbw), .opsz(64)) dut (
    .clk(clk), .rst(rst), .redir(redir), .resp(resp), .claim(claim), .wb(wb)
  );
  always #5 clk = ~clk;
  function automatic exe_bundle_t v(input int x);
    return '{opid: 16'h8000 | 16'(x), data: 32'hD000_0000 | 32'(x)};
  endfunction
  function automatic exe_bundle_t bo(input logic [15:0] o, input logic [31:0] d);
    return '{opid: o, data: d};
  endfunction
  task automatic nv();
    cur.rst = 1'b0;
    cur.redir = '0;
    cur.resp = '0;
    cur.claim = '0;
    cur.wb = '0;
  endtask
  task automatic push();
    tv.push_back(cur);
  endtask
  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec %0d got %h expected %h", nm, i, act, exp);
    end
  endtask
  initial begin
    // 0: reset held with every slot valid
    nv(); cur.rst = 1'b1;
    for (int f = 0; f < nfu; f++) for (int s = 0; s < ewd; s++) cur.resp[f][s] = v(f*4+s);
    push();
    // 1: reset released, rr=0 -> FU0 s0,s1
    cur.rst = 1'b0; cur.claim = 16'h0003; cur.wb[0] = v(0); cur.wb[1] = v(1); push();
    // 2,3: FU0 and FU2 slot 0 both granted each cycle, rr=1
    nv(); cur.resp[0][0] = v('h10); cur.resp[2][0] = v('h20);
    cur.claim = 16'h0101; cur.wb[0] = v('h20); cur.wb[1] = v('h10); push();
    nv(); cur.resp[0][0] = v('h11); cur.resp[2][0] = v('h21);
    cur.claim = 16'h0101; cur.wb[0] = v('h21); cur.wb[1] = v('h11); push();
    // 4: reset to bring rr back to 0
    nv(); cur.rst = 1'b1; push();
    // 5: FU0 s0..3 + FU2 s0, rr=0 -> FU0 s0,s1
    nv(); for (int s = 0; s < ewd; s++) cur.resp[0][s] = v('h30+s);
    cur.resp[2][0] = v('h40);
    cur.claim = 16'h0003; cur.wb[0] = v('h30); cur.wb[1] = v('h31); push();
    // 6: rr=1 -> FU2 s0 then FU0 s0
    nv(); cur.resp[0][0] = v('h32); cur.resp[0][1] = v('h33); cur.resp[2][0] = v('h40);
    cur.claim = 16'h0101; cur.wb[0] = v('h40); cur.wb[1] = v('h32); push();
    // 7: FU1 slot 0 empty, slot 1 valid -> FU1 not claimed
    nv(); cur.resp[0][0] = v('h33); cur.resp[1][1] = v('h50);
    cur.claim = 16'h0001; cur.wb[0] = v('h33); push();
    // 8: squash: topid 0x803E, opid 0x803F; 0x8001 young, 0x803E kept
    nv(); cur.redir = '{opid: 16'h803F, topid: 16'h803E};
    cur.resp[1][0] = bo(16'h8001, 32'hAAAA_0001); cur.resp[1][1] = bo(16'h803E, 32'hBBBB_003E);
    cur.claim = 16'h0030; cur.wb[1] = bo(16'h803E, 32'hBBBB_003E); push();
    // 9: rr=2 -> FU2
    nv(); cur.resp[2][0] = v('h60); cur.claim = 16'h0100; cur.wb[0] = v('h60); push();
    // 10: wrap-around, rr=3 -> FU3 then FU0, FU1 left resident
    nv(); cur.resp[3][0] = v('h70); cur.resp[0][0] = v('h71); cur.resp[1][0] = v('h72);
    cur.claim = 16'h1001; cur.wb[0] = v('h70); cur.wb[1] = v('h71); push();
    // 11-14: overflow, 8 slots drained two per cycle
    nv(); cur.resp[1][0] = v('h72); cur.resp[1][1] = v('h73);
    for (int f = 0; f < nfu; f++) if (f != 1) begin
      cur.resp[f][0] = v('h80 + (f == 0 ? 0 : 2*f)); cur.resp[f][1] = v('h81 + (f == 0 ? 0 : 2*f));
    end
    cur.claim = 16'h0030; cur.wb[0] = v('h72); cur.wb[1] = v('h73); push();
    cur.resp[1] = '0; cur.claim = 16'h0300; cur.wb[0] = v('h84); cur.wb[1] = v('h85); push();
    cur.resp[2] = '0; cur.claim = 16'h3000; cur.wb[0] = v('h86); cur.wb[1] = v('h87); push();
    cur.resp[3] = '0; cur.claim = 16'h0003; cur.wb[0] = v('h80); cur.wb[1] = v('h81); push();
    // 15-17: idle
    nv(); push(); push(); push();
    // 18: rr held at 1 across idle -> FU1 s0,s1
    nv(); cur.resp[0][0] = v('h90); cur.resp[1][0] = v('h91); cur.resp[1][1] = v('h92);
    cur.claim = 16'h0030; cur.wb[0] = v('h91); cur.wb[1] = v('h92); push();
    // 19: predicate across ring wrap: topid 60, opid 2 -> 0x8005 young, 0x803D kept
    nv(); cur.redir = '{opid: 16'h8002, topid: 16'h803C}; cur.resp[0][0] = v('h90);
    cur.resp[2][0] = bo(16'h8005, 32'hCCCC_0005); cur.resp[2][1] = bo(16'h803D, 32'hDDDD_003D);
    cur.claim = 16'h0300; cur.wb[1] = bo(16'h803D, 32'hDDDD_003D); push();
    // 20: reset mid-operation discards claims and writeback
    nv(); cur.rst = 1'b1; cur.resp[0][0] = v('h90); push();
    foreach (tv[i]) begin
      rst = tv[i].rst;
      redir = tv[i].redir;
      resp = tv[i].resp;
      #2;
      chk("claim", i, 64'(claim), 64'(tv[i].claim));
      @(posedge clk);
      #1;
      chk("wb0", i, 64'(wb[0]), 64'(tv[i].wb[0]));
      chk("wb1", i, 64'(wb[1]), 64'(tv[i].wb[1]));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter at the consumer end of the functional-unit result interface. Each cycle it inspects the `exe_bundle_t` response slots of every functional unit (ALU, MDU, FPU, LSU, ...). It asserts `claim` on the slots it accepts, and it forwards up to `wbw` accepted results through a registered writeback port to the register file and ROB. Results younger than an active redirect are drained from the FUs but never written back.

## Interface
- `nfu`, 4: number of functional units attached.
- `ewd`, 4: response slots per FU; matches the FU `ewd`.
- `wbw`, 2: writeback ports, i.e. the maximum number of results claimed per cycle.
- `opsz`, 64: operation ID ring size; power of two.

- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `redir`  in  `red_bundle_t`  redirect bundle. The redirect is active when `redir.opid[15]`=1.
- `resp`  in  `exe_bundle_t [nfu-1:0][ewd-1:0]`  FU result slots. A slot is valid when `.opid[15]`=1.
- `claim`  out  `logic [nfu-1:0][ewd-1:0]`  combinational. The FU pops the claimed slots at the next edge.
- `wb`  out  `exe_bundle_t [wbw-1:0]`  registered writeback results. A port is valid when `.opid[15]`=1; invalid ports are all-zero.

## Operation
- **Squash predicate** `young(x)`: true when all three of the following hold.
  - `redir.opid[15]` is set.
  - `x[15]` is set.
  - `(x−redir.topid) mod opsz ≥ (redir.opid−redir.topid) mod opsz + 1`, where all terms are truncated to `$clog2(opsz)` bits and the arithmetic wraps.
- **Claim rule, per FU:** the claimed slots always form a prefix `0..k-1` of that FU's valid slots.
  - Slot `i` is never claimed if slot `j<i` is unclaimed.
  - Slot `i` is never claimed if slot `i` is invalid.
- **Grant scan:**
  - FUs are visited in order `rr_ptr, rr_ptr+1, … (mod nfu)`. Within each FU, slots are visited in order `0..ewd-1`.
  - Each valid slot visited is granted until the total grant count reaches `wbw`.
  - When the first invalid slot of an FU is reached, the scan moves on to the next FU.
- **Port mapping:** granted slots fill `wb` ports 0,1,… in scan order.
  - A granted slot with `young(opid)` is still claimed, so the FU is drained, and it still consumes its port.
  - That port is written as all-zero.
- **`rr_ptr` update:**
  - After a cycle with at least one grant: `rr_ptr` ← (index of the last FU granted + 1) mod `nfu`.
  - After a cycle with no grant: `rr_ptr` is unchanged.
  - Reset value is 0.
- **Registered outputs:**
  - `wb` ← the mapped grants at the next edge.
  - If an entry being loaded satisfies `young` in the loading cycle, it is zeroed at load.
  - An entry already held in `wb` is **not** re-checked. Its consumers act on it in the cycle it is presented, before any later redirect.
- **Fairness:** any FU that is continuously valid at slot 0 is granted within `nfu` cycles.
- **Reset:**
  - `wb` = 0 and `rr_ptr` = 0.
  - `claim` = 0 while `rst` is high, regardless of `resp`.
  - Reset asserted mid-operation discards the `wb` contents at the next edge.

## Timing
- Claim to writeback latency is 1 cycle: a slot claimed in cycle t appears on `wb` in cycle t+1.
- `claim` is a pure function of `resp`, `rr_ptr`, and `rst`. It has no dependency on `redir`, so the FU's own squash and the arbiter drop are independent.
- Results are written back in every cycle; there is no backpressure from the writeback side.
- **Boundary conditions:**
  - All FUs empty: `claim`=0 in that cycle; `wb`=0 in the next cycle; `rr_ptr` holds.
  - More than `wbw` valid slots: exactly `wbw` claimed; the remainder stay resident in the FUs.
  - Wrap-around: `rr_ptr`=`nfu-1` scans FU `nfu-1` first, then FU 0.
  - The predicate wraps correctly when the ring index crosses from `opsz-1` to 0.
  - Redirect and grant in the same cycle: the slot is claimed and its `wb` port is zeroed.

## Test plan
- **Reset:** hold `rst` with all slots valid → `claim`=0 and `wb`=0. Release `rst`; in the first cycle FU0 slots 0,1 are claimed, and in the next cycle `wb[0..1]` equal those two bundles.
- **Round robin:** FU0 and FU2 slot 0 continuously valid, `wbw`=2, all other slots empty → both granted each cycle. Then make only FU0 slots 0–3 valid plus FU2 slot 0 valid, with `rr_ptr`=0 → cycle 1 grants FU0 s0,s1 and sets `rr_ptr`=1; cycle 2 grants FU2 s0 then FU0 s0.
- **Prefix rule:** FU1 slot 0 invalid, slot 1 valid → `claim[1]`=0. FU1 must never pop out of order.
- **Squash:** `redir.topid`=0x803E, `redir.opid`=0x803F, granted slot `opid`=0x8001 (ring distance 3 ≥ 2) → claimed, and `wb` port = 0. A granted slot with `opid`=0x803E in the same cycle → written back.
- **Overflow:** 8 valid slots across 4 FUs, `wbw`=2 → exactly 2 claims per cycle. All 8 are written back in 4 cycles, and none are duplicated.
- **Idle:** all `opid[15]`=0 for 3 cycles → `claim`=0, `wb`=0, `rr_ptr` unchanged.
